// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes and FSM state encoding for the sequential ALU
package seq_alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done request and result bus of the sequential ALU
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             zero;
  modport master (output start, op, a, b, input busy, done, z, zero);
  modport slave  (input start, op, a, b, output busy, done, z, zero);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational AND/OR/ADD/SUB/SLT, reserved and MUL codes yield 0
module alu_core import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  always_comb begin
    sum  = a + b;
    diff = a + ~b + WIDTH'(1);
    lt   = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
    y    = (op == OP_AND) ? (a & b) :
           (op == OP_OR)  ? (a | b) :
           (op == OP_ADD) ? sum :
           (op == OP_SUB) ? diff :
           (op == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} : '0;
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/done handshake and a WIDTH-cycle shift-add multiplier
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, z_q, z_d;
  logic [WIDTH-1:0] core_y, acc_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, done_q, done_d, busy_q, busy_d;
  alu_core #(.WIDTH(WIDTH)) u_core (.op(bus.op), .a(bus.a), .b(bus.b), .y(core_y));
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.op == OP_MUL) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = MUL;
        end else begin
          z_d     = core_y;
          state_d = DONE;
        end
      end
      MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          z_d     = acc_nxt;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (z_d == '0);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end
  assign bus.z    = z_q;
  assign bus.zero = zero_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu at WIDTH=32 and WIDTH=8 against an arithmetic model
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  seq_alu_if #(.WIDTH(32)) if32 ();
  seq_alu_if #(.WIDTH(8))  if8 ();
  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned m, ua, ub;
    longint          sa, sb;
    logic [63:0]     r;
    m  = (64'd1 << w) - 1;
    ua = {32'b0, a} & m;
    ub = {32'b0, b} & m;
    sa = ua[w-1] ? longint'(ua) - longint'(m) - 1 : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(m) - 1 : longint'(ub);
    case (op)
      3'd0:    r = ua & ub;
      3'd1:    r = ua | ub;
      3'd2:    r = (ua + ub) & m;
      3'd6:    r = (ua - ub) & m;
      3'd7:    r = (sa < sb) ? 64'd1 : 64'd0;
      3'd3:    r = (ua * ub) & m;
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit n8, input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n8) begin
      if8.start = s; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end else begin
      if32.start = s; if32.op = op; if32.a = a; if32.b = b;
    end
  endtask

  function automatic logic [34:0] outs(bit n8);
    return n8 ? {if8.busy, if8.done, if8.zero, 24'b0, if8.z} : {if32.busy, if32.done, if32.zero, if32.z};
  endfunction

  task automatic run(input bit n8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit hold, input string tag);
    int          w, lat;
    logic [31:0] exp;
    logic [34:0] o;
    w   = n8 ? 8 : 32;
    exp = ref_alu(w, op, a, b);
    @(negedge clk);
    drive(n8, 1'b1, op, a, b);
    @(negedge clk);
    lat = 1;
    drive(n8, hold, hold ? 3'd2 : op, $urandom, $urandom);
    o = outs(n8);
    chk({tag, ".busy1"}, {31'b0, o[34]}, 32'd1);
    while (!o[33] && lat < 100) begin
      @(negedge clk);
      lat++;
      drive(n8, hold, hold ? 3'd2 : op, $urandom, $urandom);
      o = outs(n8);
    end
    drive(n8, 1'b0, op, $urandom, $urandom);
    chk({tag, ".latency"}, lat, (op == 3'd3) ? w + 1 : 1);
    chk({tag, ".z"}, o[31:0], exp);
    chk({tag, ".zero"}, {31'b0, o[32]}, {31'b0, exp == 0});
    @(negedge clk);
    o = outs(n8);
    chk({tag, ".done_off"}, {30'b0, o[34:33]}, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [2:0] rop;
    logic [31:0] ra, rb, exp;
    bit n8;
    drive(1'b0, 1'b0, 3'd0, 0, 0);
    drive(1'b1, 1'b0, 3'd0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst32", {if32.busy, if32.done, if32.zero, if32.z[28:0]}, 32'h2000_0000);
    chk("rst8", {21'b0, if8.busy, if8.done, if8.zero, if8.z}, 32'h100);
    reset = 1'b0;
    run(0, 3'd2, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
    run(0, 3'd6, 32'd5, 32'd7, 0, "sub");
    run(0, 3'd7, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
    run(0, 3'd7, 32'h7FFF_FFFF, 32'h8000_0000, 0, "slt_ovf");
    run(0, 3'd7, 32'd3, 32'd3, 0, "slt_eq");
    run(1, 3'd3, 32'd13, 32'd11, 0, "mul8");
    run(1, 3'd3, 32'hFF, 32'hFF, 0, "mul8_ff");
    run(0, 3'd3, 32'd0, 32'h1234_5678, 0, "mul32_zero");
    run(1, 3'd3, 32'd13, 32'd11, 1, "mul8_ignore");
    run(0, 3'd5, 32'hDEAD, 32'hBEEF, 0, "reserved");
    run(0, 3'd6, 32'd5, 32'd7, 0, "pre_reset");
    @(negedge clk);
    drive(0, 1'b1, 3'd3, 32'd7, 32'd9);
    @(negedge clk);
    drive(0, 1'b0, 3'd3, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst", {if32.busy, if32.done, if32.zero, if32.z[28:0]}, 32'h2000_0000);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.done) pulses++;
    end
    chk("midrst.nodone", pulses, 0);
    run(0, 3'd2, 32'd1, 32'd1, 0, "post_reset_add");
    for (int i = 0; i < 6; i++) begin
      rop = (i % 2 == 0) ? 3'd2 : 3'd6;
      ra = $urandom; rb = $urandom;
      exp = ref_alu(32, rop, ra, rb);
      drive(0, 1'b1, rop, ra, rb);
      @(negedge clk);
      chk($sformatf("b2b%0d.done", i), {31'b0, if32.done}, 32'd1);
      chk($sformatf("b2b%0d.z", i), if32.z, exp);
      @(negedge clk);
      chk($sformatf("b2b%0d.gap", i), {31'b0, if32.done}, 32'd0);
    end
    drive(0, 1'b0, 3'd0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n8 = $urandom_range(0, 1) == 1;
      rop = 3'($urandom_range(0, 7));
      ra = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
      rb = $urandom;
      run(n8, rop, ra, rb, 0, $sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
